// File: rtl/nvram_pkg.sv
// ---------------------------------------------------------------------------
// nvram_pkg
// Shared definitions for the NVRAM upload engine:
//   - nvram_state_t : upload FSM states
//   - FILL_BYTE     : value returned for offsets outside the window
//   - CSUM_W        : width of the optional upload checksum accumulator
// ---------------------------------------------------------------------------
package nvram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAUSE   = 3'd1,
        READY   = 3'd2,
        FETCH   = 3'd3,
        RELEASE = 3'd4
    } nvram_state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;
    localparam int         CSUM_W    = 8;

endpackage

// File: rtl/nvram_rd_pipe.sv
// ---------------------------------------------------------------------------
// nvram_rd_pipe
// RD_LAT-deep valid shift register tracking one outstanding RAM read.
// o_valid is high in the cycle ram_q carries the data for a read issued
// RD_LAT cycles earlier.
// Ports:
//   i_clk    : clock
//   i_reset  : synchronous active-high reset
//   i_flush  : drop anything in flight (session teardown)
//   i_issue  : a RAM read is issued this cycle
//   o_valid  : RAM data for the oldest issued read is on ram_q now
// ---------------------------------------------------------------------------
module nvram_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_flush,
    input  logic i_issue,
    output logic o_valid
);

    logic [RD_LAT-1:0] r_shift;

    generate
        if (RD_LAT == 1) begin : g_one
            always_ff @(posedge i_clk) begin
                if (i_reset || i_flush) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= i_issue;
                end
            end
        end else begin : g_multi
            always_ff @(posedge i_clk) begin
                if (i_reset || i_flush) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= {r_shift[RD_LAT-2:0], i_issue};
                end
            end
        end
    endgenerate

    assign o_valid = r_shift[RD_LAT-1];

endmodule

// File: rtl/nvram_upload_engine.sv
// ---------------------------------------------------------------------------
// nvram_upload_engine
// Streams a window of CPU work RAM (hiscore / NVRAM) to the HPS upload port.
// The CPU is paused through pause_req/pause_ack while a session is active,
// and RAM is read through the spare display-side port.
//
// Optional feature macro: NVRAM_CHECKSUM_EN
//   defined   : an 8-bit sum of the bytes served in the session is kept, and
//               a read of offset LEN returns its complement (latency 1).
//   undefined : offset LEN is just another out-of-range offset (FF).
//
// Ports:
//   i_clk_18m   : sole clock
//   i_reset     : synchronous active-high reset
//   i_up_active : upload session in progress (level)
//   i_up_addr   : byte offset requested by the HPS, valid with i_up_rd
//   i_up_rd     : one-cycle read strobe
//   o_up_din    : byte returned to the HPS
//   o_up_wait   : read outstanding, or session not yet paused
//   o_pause_req : CPU halt request
//   i_pause_ack : CPU halted at an instruction boundary
//   o_ram_addr  : RAM read address
//   o_ram_rd    : RAM read enable (one cycle per fetch)
//   i_ram_q     : RAM data, valid RD_LAT cycles after o_ram_rd
//   o_err       : sticky error (pause timeout, strobe while busy, ack lost)
//   o_state     : current FSM state, for observation
//
// HPS handshake: i_up_rd is a single-cycle request that carries i_up_addr.
// A request is only accepted in READY. In-window requests raise o_up_wait
// in the strobe cycle and keep it high until the cycle o_up_din holds the
// byte (RD_LAT+1 cycles after the strobe). Out-of-window requests leave
// o_up_wait low and update o_up_din on the next cycle. A strobe arriving
// in any other session state is dropped and flagged in o_err.
// ---------------------------------------------------------------------------
module nvram_upload_engine
    import nvram_pkg::*;
#(
    parameter int RAM_AW   = 11,   // must not exceed the 14-bit offset width
    parameter int BASE     = 0,
    parameter int LEN      = 256,
    parameter int RD_LAT   = 1,
    parameter int PAUSE_TO = 1023
) (
    input  logic              i_clk_18m,
    input  logic              i_reset,
    input  logic              i_up_active,
    input  logic [13:0]       i_up_addr,
    input  logic              i_up_rd,
    output logic [7:0]        o_up_din,
    output logic              o_up_wait,
    output logic              o_pause_req,
    input  logic              i_pause_ack,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_rd,
    input  logic [7:0]        i_ram_q,
    output logic              o_err,
    output nvram_state_t      o_state
);

    // The pause timer counts PAUSE cycles 0..PAUSE_TO-1; the last one
    // without an ack gives up.
    localparam int                 TIMER_W    = (PAUSE_TO < 2) ? 1 : $clog2(PAUSE_TO);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PAUSE_TO - 1);
    localparam logic [14:0]        LEN_W      = 15'(LEN);

    nvram_state_t        r_state;
    nvram_state_t        w_state_nxt;
    logic                r_active_d;
    logic                r_pause_req;
    logic                w_pause_req_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [TIMER_W-1:0]  r_timer;
    logic [TIMER_W-1:0]  w_timer_nxt;
    logic [7:0]          r_up_din;
    logic [7:0]          w_up_din_nxt;
    logic [RAM_AW-1:0]   r_ram_addr;
    logic [RAM_AW-1:0]   w_ram_addr;
    logic                w_fire;
    logic                w_up_wait;
    logic                w_in_range;
    logic                w_active_rise;
    logic                w_q_valid;
    logic                w_flush;

`ifdef NVRAM_CHECKSUM_EN
    logic [CSUM_W-1:0]   r_acc;
    logic [CSUM_W-1:0]   w_acc_nxt;
    logic                w_csum_slot;

    assign w_csum_slot = ({1'b0, i_up_addr} == LEN_W);
`endif

    assign w_active_rise = i_up_active & ~r_active_d;
    assign w_in_range    = ({1'b0, i_up_addr} < LEN_W);
    // Window start plus offset, wrapping within the RAM address space.
    assign w_ram_addr    = RAM_AW'(BASE) + i_up_addr[RAM_AW-1:0];
    // Anything still in the read pipe when a session ends is stale.
    assign w_flush       = (r_state == RELEASE);

    nvram_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (i_clk_18m),
        .i_reset (i_reset),
        .i_flush (w_flush),
        .i_issue (w_fire),
        .o_valid (w_q_valid)
    );

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_18m) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_active_d  <= 1'b0;
            r_pause_req <= 1'b0;
            r_err       <= 1'b0;
            r_timer     <= '0;
            r_up_din    <= FILL_BYTE;
            r_ram_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_active_d  <= i_up_active;
            r_pause_req <= w_pause_req_nxt;
            r_err       <= w_err_nxt;
            r_timer     <= w_timer_nxt;
            r_up_din    <= w_up_din_nxt;
            if (w_fire) begin
                r_ram_addr <= w_ram_addr;
            end
        end
    end

`ifdef NVRAM_CHECKSUM_EN
    always_ff @(posedge i_clk_18m) begin
        if (i_reset) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_pause_req_nxt = r_pause_req;
        w_err_nxt       = r_err;
        w_timer_nxt     = r_timer;
        w_up_din_nxt    = r_up_din;
        w_fire          = 1'b0;
        w_up_wait       = 1'b0;
`ifdef NVRAM_CHECKSUM_EN
        w_acc_nxt       = r_acc;
`endif

        case (r_state)
            IDLE: begin
                // Sessions start on the rising edge only, so a timed-out
                // session with up_active still high does not retry forever.
                if (w_active_rise) begin
                    w_state_nxt     = PAUSE;
                    w_pause_req_nxt = 1'b1;
                    w_timer_nxt     = '0;
                    // A strobe in the start cycle cannot be served.
                    w_err_nxt       = i_up_rd;
`ifdef NVRAM_CHECKSUM_EN
                    w_acc_nxt       = '0;
`endif
                end
            end

            PAUSE: begin
                w_up_wait   = 1'b1;
                w_timer_nxt = r_timer + 1'b1;
                if (i_up_rd) begin
                    w_err_nxt = 1'b1;
                end
                if (!i_up_active) begin
                    w_state_nxt = RELEASE;
                end else if (i_pause_ack) begin
                    w_state_nxt = READY;
                end else if (r_timer == TIMER_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end

            READY: begin
                // Losing the halt mid-session is reported but not fatal.
                if (!i_pause_ack) begin
                    w_err_nxt = 1'b1;
                end
                if (!i_up_active) begin
                    w_state_nxt = RELEASE;
                end else if (i_up_rd) begin
                    if (w_in_range) begin
                        w_fire      = 1'b1;
                        w_up_wait   = 1'b1;
                        w_state_nxt = FETCH;
`ifdef NVRAM_CHECKSUM_EN
                    end else if (w_csum_slot) begin
                        w_up_din_nxt = ~r_acc;
`endif
                    end else begin
                        w_up_din_nxt = FILL_BYTE;
                    end
                end
            end

            FETCH: begin
                w_up_wait = 1'b1;
                if (!i_pause_ack || i_up_rd) begin
                    w_err_nxt = 1'b1;
                end
                // Session end wins over a byte arriving in the same cycle.
                if (!i_up_active) begin
                    w_state_nxt = RELEASE;
                end else if (w_q_valid) begin
                    w_up_din_nxt = i_ram_q;
                    w_state_nxt  = READY;
`ifdef NVRAM_CHECKSUM_EN
                    w_acc_nxt    = r_acc + i_ram_q;
`endif
                end
            end

            RELEASE: begin
                w_pause_req_nxt = 1'b0;
                if (i_up_rd) begin
                    w_err_nxt = 1'b1;
                end
                w_state_nxt = IDLE;
            end

            default: begin
                w_pause_req_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    assign o_up_din    = r_up_din;
    assign o_up_wait   = w_up_wait;
    assign o_pause_req = r_pause_req;
    assign o_ram_rd    = w_fire;
    // Address is live in the strobe cycle and held afterwards.
    assign o_ram_addr  = w_fire ? w_ram_addr : r_ram_addr;
    assign o_err       = r_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_nvram_upload_engine.sv
// ---------------------------------------------------------------------------
// tb_nvram_upload_engine
// Directed bench for nvram_upload_engine with default parameters
// (RAM_AW=11, BASE=0, LEN=256, RD_LAT=1, PAUSE_TO=1023).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_nvram_upload_engine;
    import nvram_pkg::*;

    localparam int RAM_AW   = 11;
    localparam int BASE     = 0;
    localparam int LEN      = 256;
    localparam int RD_LAT   = 1;
    localparam int PAUSE_TO = 1023;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              up_active;
    logic [13:0]       up_addr;
    logic              up_rd;
    logic [7:0]        up_din;
    logic              up_wait;
    logic              pause_req;
    logic              pause_ack;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_q;
    logic              err;
    nvram_state_t      state;

    nvram_upload_engine #(
        .RAM_AW   (RAM_AW),
        .BASE     (BASE),
        .LEN      (LEN),
        .RD_LAT   (RD_LAT),
        .PAUSE_TO (PAUSE_TO)
    ) u_dut (
        .i_clk_18m   (clk),
        .i_reset     (reset),
        .i_up_active (up_active),
        .i_up_addr   (up_addr),
        .i_up_rd     (up_rd),
        .o_up_din    (up_din),
        .o_up_wait   (up_wait),
        .o_pause_req (pause_req),
        .i_pause_ack (pause_ack),
        .o_ram_addr  (ram_addr),
        .o_ram_rd    (ram_rd),
        .i_ram_q     (ram_q),
        .o_err       (err),
        .o_state     (state)
    );

    // ---------------- RAM model (RD_LAT = 1) ----------------
    logic [7:0] mem [0:(1<<RAM_AW)-1];
    int         rd_cnt = 0;

    always @(posedge clk) begin
        if (ram_rd) begin
            ram_q  <= mem[ram_addr];
            rd_cnt <= rd_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    typedef struct {
        logic [13:0] addr;
        logic [7:0]  din;
        logic        via_ram;
    } vec_t;

    // Issues one read from READY and checks wait, RAM access and returned byte.
    task automatic do_read(input vec_t v);
        int                cnt0;
        logic [RAM_AW-1:0] exp_addr;
        cnt0     = rd_cnt;
        exp_addr = RAM_AW'(BASE + int'(v.addr));
        up_addr  = v.addr;
        up_rd    = 1'b1;
        settle();
        check("rd_wait_strobe", up_wait, v.via_ram);
        check("rd_ram_rd", ram_rd, v.via_ram);
        if (v.via_ram) begin
            check("rd_ram_addr", ram_addr, exp_addr);
        end
        next_cycle();
        up_rd = 1'b0;
        if (v.via_ram) begin
            settle();
            check("rd_wait_fetch", up_wait, 1'b1);
            check("rd_state_fetch", state, FETCH);
            next_cycle();
        end
        settle();
        check("rd_din", up_din, v.din);
        check("rd_wait_done", up_wait, 1'b0);
        check("rd_state_ready", state, READY);
        check("rd_ram_count", 16'(rd_cnt - cnt0), v.via_ram);
        next_cycle();
    endtask

    vec_t vec [8];

    initial begin
        vec[0] = '{14'd3,     8'hA5, 1'b1};
        vec[1] = '{14'd300,   8'hFF, 1'b0};
        vec[2] = '{14'd0,     8'h01, 1'b1};
`ifdef NVRAM_CHECKSUM_EN
        vec[3] = '{14'd256,   8'h59, 1'b0};   // ~(A5 + 01)
`else
        vec[3] = '{14'd256,   8'hFF, 1'b0};
`endif
        vec[4] = '{14'd255,   8'h3C, 1'b1};
        vec[5] = '{14'd16383, 8'hFF, 1'b0};
        vec[6] = '{14'd128,   8'hC3, 1'b1};
        vec[7] = '{14'd257,   8'hFF, 1'b0};

        for (int i = 0; i < (1 << RAM_AW); i++) begin
            mem[i] = 8'(i * 7 + 16);
        end
        mem[0]   = 8'h01;
        mem[1]   = 8'h02;
        mem[2]   = 8'h03;
        mem[3]   = 8'hA5;
        mem[128] = 8'hC3;
        mem[255] = 8'h3C;

        reset     = 1'b1;
        up_active = 1'b0;
        up_addr   = '0;
        up_rd     = 1'b0;
        pause_ack = 1'b0;

        // ---- reset values ----
        repeat (3) next_cycle();
        settle();
        check("rst_din", up_din, 8'hFF);
        check("rst_wait", up_wait, 1'b0);
        check("rst_pause_req", pause_req, 1'b0);
        check("rst_ram_rd", ram_rd, 1'b0);
        check("rst_ram_addr", ram_addr, '0);
        check("rst_err", err, 1'b0);
        check("rst_state", state, IDLE);
        next_cycle();
        reset = 1'b0;

        // ---- session start, ack after 5 PAUSE cycles ----
        up_active = 1'b1;
        settle();
        check("start_idle", state, IDLE);
        next_cycle();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) pause_ack = 1'b1;
            settle();
            check("pause_req_high", pause_req, 1'b1);
            check("pause_wait_high", up_wait, 1'b1);
            check("pause_state", state, PAUSE);
            next_cycle();
        end
        settle();
        check("ready_wait_low", up_wait, 1'b0);
        check("ready_state", state, READY);
        check("ready_err", err, 1'b0);
        next_cycle();

        // ---- table of single reads ----
        for (int v = 0; v < 8; v++) begin
            do_read(vec[v]);
        end

        // ---- second strobe while fetching ----
        begin
            int cnt0;
            cnt0    = rd_cnt;
            up_addr = 14'd3;
            up_rd   = 1'b1;
            next_cycle();
            up_addr = 14'd0;
            up_rd   = 1'b1;
            settle();
            check("busy_no_ram_rd", ram_rd, 1'b0);
            check("busy_err_before", err, 1'b0);
            next_cycle();
            up_rd = 1'b0;
            settle();
            check("busy_err", err, 1'b1);
            check("busy_din", up_din, 8'hA5);
            check("busy_state", state, READY);
            check("busy_ram_count", 16'(rd_cnt - cnt0), 16'd1);
            next_cycle();
        end

        // ---- session end: RELEASE then IDLE ----
        up_active = 1'b0;
        next_cycle();
        settle();
        check("end_release", state, RELEASE);
        check("end_release_wait", up_wait, 1'b0);
        next_cycle();
        settle();
        check("end_idle", state, IDLE);
        check("end_pause_req", pause_req, 1'b0);
        check("end_err_sticky", err, 1'b1);
        next_cycle();

        // ---- new session clears err; ack drop in READY ----
        up_active = 1'b1;
        next_cycle();
        settle();
        check("s2_err_cleared", err, 1'b0);
        check("s2_pause", state, PAUSE);
        next_cycle();
        pause_ack = 1'b0;
        settle();
        check("s2_ready", state, READY);
        next_cycle();
        pause_ack = 1'b1;
        settle();
        check("ackdrop_err", err, 1'b1);
        check("ackdrop_state", state, READY);
        next_cycle();

        // ---- fetch discarded by session end ----
        do_read('{14'd300, 8'hFF, 1'b0});
        up_addr = 14'd3;
        up_rd   = 1'b1;
        next_cycle();
        up_rd     = 1'b0;
        up_active = 1'b0;
        settle();
        check("discard_fetch", state, FETCH);
        next_cycle();
        settle();
        check("discard_release", state, RELEASE);
        check("discard_din_rel", up_din, 8'hFF);
        next_cycle();
        settle();
        check("discard_idle", state, IDLE);
        check("discard_din_idle", up_din, 8'hFF);
        check("discard_pause_req", pause_req, 1'b0);
        next_cycle();

        // ---- strobe in the session start cycle ----
        pause_ack = 1'b0;
        up_active = 1'b1;
        up_addr   = 14'd5;
        up_rd     = 1'b1;
        next_cycle();
        up_rd = 1'b0;
        settle();
        check("startrd_state", state, PAUSE);
        check("startrd_err", err, 1'b1);
        up_active = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        check("startrd_idle", state, IDLE);
        next_cycle();

        // ---- pause timeout ----
        up_active = 1'b1;
        next_cycle();
        settle();
        check("to_err_cleared", err, 1'b0);
        check("to_pause", state, PAUSE);
        next_cycle();
        repeat (PAUSE_TO - 2) next_cycle();
        settle();
        check("to_err_last", err, 1'b0);
        check("to_state_last", state, PAUSE);
        next_cycle();
        settle();
        check("to_err_set", err, 1'b1);
        check("to_release", state, RELEASE);
        check("to_req_still", pause_req, 1'b1);
        next_cycle();
        settle();
        check("to_req_drop", pause_req, 1'b0);
        check("to_idle", state, IDLE);
        next_cycle();
        settle();
        check("to_no_rearm", state, IDLE);
        up_active = 1'b0;
        next_cycle();

        // ---- reset mid-session ----
        up_active = 1'b1;
        pause_ack = 1'b1;
        next_cycle();
        next_cycle();
        settle();
        check("mid_ready", state, READY);
        check("mid_req", pause_req, 1'b1);
        next_cycle();
        reset     = 1'b1;
        up_active = 1'b0;
        next_cycle();
        reset = 1'b0;
        settle();
        check("mid_rst_req", pause_req, 1'b0);
        check("mid_rst_state", state, IDLE);
        check("mid_rst_wait", up_wait, 1'b0);
        next_cycle();

`ifdef NVRAM_CHECKSUM_EN
        // ---- checksum slot ----
        up_active = 1'b1;
        next_cycle();
        next_cycle();
        do_read('{14'd0,   8'h01, 1'b1});
        do_read('{14'd1,   8'h02, 1'b1});
        do_read('{14'd2,   8'h03, 1'b1});
        do_read('{14'd256, 8'hF9, 1'b0});
        up_active = 1'b0;
        next_cycle();
        next_cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
